// File: rtl/bcd_fmt_pkg.sv
// Shared ASCII constants, FSM state encoding and digit helpers for the BCD-to-ASCII
// transmitter.
package bcd_fmt_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [2:0] {
        StIdle,
        StSign,
        StDigit,
        StCr,
        StLf
    } state_t;

    function automatic logic [7:0] digit_char(input logic [3:0] nib);
        return (nib > 4'd9) ? ASCII_QMARK : (ASCII_ZERO + {4'h0, nib});
    endfunction

    // Index of the most significant non-zero nibble; the ones digit is the floor.
    function automatic logic [1:0] msd_index(input logic [15:0] digits);
        if (digits[15:12] != 4'h0) return 2'd3;
        else if (digits[11:8] != 4'h0) return 2'd2;
        else if (digits[7:4] != 4'h0) return 2'd1;
        else return 2'd0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset and a combinational read port.
module sync_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_pop  = pop && !empty;
        // A full FIFO still accepts a write when the same edge frees a slot.
        do_push = push && (!full || do_pop);
        rdata   = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/bcd2ascii_tx.sv
// Buffers signed 4-digit BCD samples and streams each one out as ASCII text, optionally
// terminated by CR LF, over a valid/ready byte interface.
module bcd2ascii_tx
    import bcd_fmt_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          EOL_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] bcd,
    input  logic        bcd_vid,
    output logic [7:0]  tx_data,
    output logic        tx_vld,
    input  logic        tx_rdy,
    input  logic        ovf_clr,
    output logic        ovf,
    output logic        bcd_err,
    output logic        busy
);

    logic [16:0] fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        drop;
    logic        accept;
    logic        last_char;

    state_t      state;
    logic [15:0] frame;
    logic [1:0]  idx;
    logic [1:0]  next_idx;
    logic [1:0]  load_idx;
    logic        load_neg;
    logic [3:0]  load_nib;
    logic [3:0]  cur_nib;
    logic [3:0]  next_nib;

    sync_fifo #(
        .WIDTH (17),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (bcd),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        accept    = tx_vld && tx_rdy;
        last_char = EOL_EN ? (state == StLf) : (state == StDigit && idx == 2'd0);
        // Popping on the final accepted byte chains frames without an idle gap.
        pop       = !fifo_empty && (state == StIdle || (accept && last_char));
        push      = bcd_vid && (!fifo_full || pop);
        drop      = bcd_vid && fifo_full && !pop;
        load_idx  = msd_index(fifo_rdata[15:0]);
        load_neg  = fifo_rdata[16] && (fifo_rdata[15:0] != 16'h0);
        load_nib  = fifo_rdata[{load_idx, 2'b00} +: 4];
        next_idx  = idx - 2'd1;
        cur_nib   = frame[{idx, 2'b00} +: 4];
        next_nib  = frame[{next_idx, 2'b00} +: 4];
        busy      = !fifo_empty || (state != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StIdle;
            frame   <= '0;
            idx     <= '0;
            tx_vld  <= 1'b0;
            tx_data <= 8'h00;
            ovf     <= 1'b0;
            bcd_err <= 1'b0;
        end else begin
            if (drop)         ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;

            if (pop) begin
                frame  <= fifo_rdata[15:0];
                idx    <= load_idx;
                tx_vld <= 1'b1;
                if (load_neg) begin
                    state   <= StSign;
                    tx_data <= ASCII_MINUS;
                end else begin
                    state   <= StDigit;
                    tx_data <= digit_char(load_nib);
                    if (load_nib > 4'd9) bcd_err <= 1'b1;
                end
            end else if (accept) begin
                case (state)
                    StSign: begin
                        state   <= StDigit;
                        tx_data <= digit_char(cur_nib);
                        if (cur_nib > 4'd9) bcd_err <= 1'b1;
                    end
                    StDigit: begin
                        if (idx != 2'd0) begin
                            idx     <= next_idx;
                            tx_data <= digit_char(next_nib);
                            if (next_nib > 4'd9) bcd_err <= 1'b1;
                        end else if (EOL_EN) begin
                            state   <= StCr;
                            tx_data <= ASCII_CR;
                        end else begin
                            state   <= StIdle;
                            tx_vld  <= 1'b0;
                            tx_data <= 8'h00;
                        end
                    end
                    StCr: begin
                        state   <= StLf;
                        tx_data <= ASCII_LF;
                    end
                    default: begin
                        state   <= StIdle;
                        tx_vld  <= 1'b0;
                        tx_data <= 8'h00;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd2ascii_tx.sv
// Directed, table-driven bench for bcd2ascii_tx with FIFO_DEPTH=4 and EOL_EN=1.
module tb_bcd2ascii_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] bcd;
    logic        bcd_vid;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic        tx_rdy;
    logic        ovf_clr;
    logic        ovf;
    logic        bcd_err;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] rxq[$];
    int         rxc[$];

    typedef struct {
        logic [16:0] bcd;
        int          n;
        logic [47:0] bytes;   // first byte in bits 47:40
        logic        err;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    bcd2ascii_tx #(
        .FIFO_DEPTH (4),
        .EOL_EN     (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bcd     (bcd),
        .bcd_vid (bcd_vid),
        .tx_data (tx_data),
        .tx_vld  (tx_vld),
        .tx_rdy  (tx_rdy),
        .ovf_clr (ovf_clr),
        .ovf     (ovf),
        .bcd_err (bcd_err),
        .busy    (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!rst && tx_vld && tx_rdy) begin
            rxq.push_back(tx_data);
            rxc.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_bcd(input logic [16:0] v, output int vc);
        bcd     = v;
        bcd_vid = 1'b1;
        vc      = cyc;
        @(negedge clk);
        bcd_vid = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int t = 0;
        while (rxq.size() < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (rxq.size() < n) begin
            checks++;
            failures++;
            $display("FAIL timeout: got %0d bytes expected %0d", rxq.size(), n);
        end
    endtask

    task automatic clear_rx();
        rxq.delete();
        rxc.delete();
    endtask

    task automatic check_frame(input string name, input logic [47:0] bytes, input int n,
                               input int vc, input bit timing);
        wait_bytes(n);
        for (int i = 0; i < n && i < rxq.size(); i++) begin
            check($sformatf("%s byte%0d", name, i), 32'(rxq[i]), 32'(bytes[47-8*i -: 8]));
            if (timing)
                check($sformatf("%s cycle%0d", name, i), 32'(rxc[i]), 32'(vc + 2 + i));
        end
        repeat (3) @(negedge clk);
        check({name, " count"}, 32'(rxq.size()), 32'(n));
        check({name, " idle"}, {30'h0, tx_vld, busy}, 32'h0);
        clear_rx();
    endtask

    initial begin
        int vc;

        vecs[0] = '{17'h0_1024, 6, 48'h3130_3234_0D0A, 1'b0};
        vecs[1] = '{17'h1_0007, 4, 48'h2D37_0D0A_0000, 1'b0};
        vecs[2] = '{17'h1_0000, 3, 48'h300D_0A00_0000, 1'b0};
        vecs[3] = '{17'h0_0000, 3, 48'h300D_0A00_0000, 1'b0};
        vecs[4] = '{17'h0_9999, 6, 48'h3939_3939_0D0A, 1'b0};
        vecs[5] = '{17'h1_0450, 6, 48'h2D34_3530_0D0A, 1'b0};
        vecs[6] = '{17'h0_00A3, 4, 48'h3F33_0D0A_0000, 1'b1};

        rst = 1'b1; bcd = '0; bcd_vid = 1'b0; tx_rdy = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", {20'h0, tx_data, tx_vld, ovf, bcd_err, busy}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        tx_rdy = 1'b1;
        for (int v = 0; v < 7; v++) begin
            pulse_bcd(vecs[v].bcd, vc);
            check_frame($sformatf("vec%0d", v), vecs[v].bytes, vecs[v].n, vc, 1'b1);
            check($sformatf("vec%0d bcd_err", v), 32'(bcd_err), 32'(vecs[v].err));
        end

        // Backpressure mid-frame holds the pending byte.
        pulse_bcd(17'h0_0305, vc);
        wait_bytes(1);
        tx_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall hold%0d", k), {23'h0, tx_vld, tx_data}, 32'h130);
        end
        check("stall no accept", 32'(rxq.size()), 32'd1);
        tx_rdy = 1'b1;
        check_frame("stall", 48'h3330_350D_0A00, 5, vc, 1'b0);

        // Overflow: one frame in the FSM, four buffered, sixth dropped.
        tx_rdy = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            pulse_bcd(17'(k), vc);
            if (k == 5) check("ovf before drop", 32'(ovf), 32'd0);
        end
        check("ovf after drop", {30'h0, ovf, busy}, 32'h3);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf cleared", 32'(ovf), 32'd0);
        bcd = 17'h0_0007; bcd_vid = 1'b1; ovf_clr = 1'b1;
        @(negedge clk);
        bcd_vid = 1'b0; ovf_clr = 1'b0;
        check("ovf set wins", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf cleared again", 32'(ovf), 32'd0);
        check("no output under stall", 32'(rxq.size()), 32'd0);
        tx_rdy = 1'b1;
        wait_bytes(15);
        for (int k = 0; k < 5 && 3*k+2 < rxq.size(); k++) begin
            check($sformatf("ovf frame%0d digit", k), 32'(rxq[3*k]), 32'h31 + 32'(k));
            check($sformatf("ovf frame%0d cr", k), 32'(rxq[3*k+1]), 32'h0D);
            check($sformatf("ovf frame%0d lf", k), 32'(rxq[3*k+2]), 32'h0A);
            check($sformatf("ovf frame%0d gapless", k), 32'(rxc[3*k+2]), 32'(rxc[0] + 3*k + 2));
        end
        repeat (3) @(negedge clk);
        check("ovf total bytes", 32'(rxq.size()), 32'd15);
        clear_rx();

        // Reset mid-frame aborts output and ignores bcd_vid.
        pulse_bcd(17'h0_1024, vc);
        wait_bytes(2);
        rst = 1'b1; bcd = 17'h0_0099; bcd_vid = 1'b1;
        @(negedge clk);
        bcd_vid = 1'b0;
        check("rst mid-frame", {20'h0, tx_data, tx_vld, ovf, bcd_err, busy}, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst no further bytes", 32'(rxq.size()), 32'd2);
        check("rst still idle", {30'h0, tx_vld, busy}, 32'h0);
        clear_rx();
        pulse_bcd(17'h0_0042, vc);
        check_frame("after rst", 48'h3432_0D0A_0000, 4, vc, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
